// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit seven-segment
// display sharing one seg_7 decoder. A new value is latched into a pending
// buffer on load and promoted to the displayed value only at a frame boundary,
// so a frame never mixes old and new digits. Each slot opens with a blanked
// interval to suppress ghosting while the digit enable switches.
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic        lz_en_in,
    output logic [3:0]  seg_num,
    output logic [3:0]  digit_en,
    output logic        frame_done,
    output logic        load_ack
);

    localparam int             TW        = $clog2(SCAN_DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0]  BLANK_T   = TW'(BLANK_CYC);
    localparam logic [3:0]     CODE_BLANK = 4'hF;

    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    slot_q, slot_d;
    logic [15:0]   active_val_q, active_val_d;
    logic          active_lz_q, active_lz_d;
    logic [15:0]   pend_val_q, pend_val_d;
    logic          pend_lz_q, pend_lz_d;
    logic          pend_vld_q, pend_vld_d;
    logic [3:0]    seg_num_q, seg_num_d;
    logic [3:0]    digit_en_q, digit_en_d;
    logic          frame_done_q, frame_done_d;
    logic          load_ack_q, load_ack_d;

    logic          last_tick;
    logic          boundary;
    logic [3:0]    zero_mask;
    logic [3:0]    nibble;

    // Bit k is set when digit k and every higher digit are zero; digit 0 is
    // never flagged so an all-zero value still shows a single "0".
    function automatic logic [3:0] lead_zero_mask(input logic [15:0] v);
        logic [3:0] m;
        m[3] = (v[15:12] == 4'h0);
        m[2] = m[3] && (v[11:8] == 4'h0);
        m[1] = m[2] && (v[7:4] == 4'h0);
        m[0] = 1'b0;
        return m;
    endfunction

    // Scan counters and frame-boundary detection.
    always_comb begin
        last_tick = (tick_q == TICK_LAST);
        boundary  = last_tick && (slot_q == 2'd3);
        tick_d    = last_tick ? '0 : tick_q + 1'b1;
        slot_d    = last_tick ? slot_q + 2'd1 : slot_q;
    end

    // Pending/active value handover; a load in the boundary cycle bypasses
    // the pending buffer so it still lands in the next frame.
    always_comb begin
        active_val_d = active_val_q;
        active_lz_d  = active_lz_q;
        pend_val_d   = pend_val_q;
        pend_lz_d    = pend_lz_q;
        pend_vld_d   = pend_vld_q;
        load_ack_d   = 1'b0;
        frame_done_d = boundary;
        if (boundary) begin
            if (load) begin
                active_val_d = value_in;
                active_lz_d  = lz_en_in;
            end else if (pend_vld_q) begin
                active_val_d = pend_val_q;
                active_lz_d  = pend_lz_q;
            end
            load_ack_d = load | pend_vld_q;
            pend_vld_d = 1'b0;
        end else if (load) begin
            pend_val_d = value_in;
            pend_lz_d  = lz_en_in;
            pend_vld_d = 1'b1;
        end
    end

    // Registered outputs computed for the upcoming (slot, tick) position.
    always_comb begin
        zero_mask  = lead_zero_mask(active_val_d);
        nibble     = active_val_d[{slot_d, 2'b00} +: 4];
        digit_en_d = 4'b1111;
        seg_num_d  = CODE_BLANK;
        if (tick_d >= BLANK_T) begin
            digit_en_d = ~(4'b0001 << slot_d);
            seg_num_d  = (active_lz_d && zero_mask[slot_d]) ? CODE_BLANK : nibble;
        end
    end

    // State register; reset discards any pending load without acknowledging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q       <= '0;
            slot_q       <= 2'd0;
            active_val_q <= 16'hFFFF;
            active_lz_q  <= 1'b0;
            pend_val_q   <= 16'h0000;
            pend_lz_q    <= 1'b0;
            pend_vld_q   <= 1'b0;
            seg_num_q    <= CODE_BLANK;
            digit_en_q   <= 4'b1111;
            frame_done_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            slot_q       <= slot_d;
            active_val_q <= active_val_d;
            active_lz_q  <= active_lz_d;
            pend_val_q   <= pend_val_d;
            pend_lz_q    <= pend_lz_d;
            pend_vld_q   <= pend_vld_d;
            seg_num_q    <= seg_num_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
            load_ack_q   <= load_ack_d;
        end
    end

    assign seg_num    = seg_num_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;
    assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with an 8-cycle slot and 2 blank cycles (32-cycle
// frame). Stimulus is driven and outputs are sampled on the falling edge;
// cycle 0 is the first cycle after reset release.
module tb_seg_scan_ctrl;

    localparam int SD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic        lz_en_in = 1'b0;
    logic [3:0]  seg_num;
    logic [3:0]  digit_en;
    logic        frame_done;
    logic        load_ack;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] val;
        logic        lz;
        logic [15:0] disp;
    } vec_t;

    vec_t vecs[8];

    seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value_in   (value_in),
        .lz_en_in   (lz_en_in),
        .seg_num    (seg_num),
        .digit_en   (digit_en),
        .frame_done (frame_done),
        .load_ack   (load_ack)
    );

    always #5 clk = ~clk;

    // Enables must never overlap, checked in every running cycle.
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if ($countones(~digit_en) > 1) begin
                fails++;
                $display("FAIL overlap cyc=%0d digit_en=%b required at most one low bit", cyc, digit_en);
            end
        end
    end

    task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // disp is the hand-computed shown code per digit after suppression.
    task automatic check(input logic [15:0] disp, input logic efd, input logic eack);
        int t;
        int s;
        logic [3:0] een;
        logic [3:0] eseg;
        t = cyc % SD;
        s = (cyc / SD) % 4;
        if (t < BC) begin
            een  = 4'b1111;
            eseg = 4'hF;
        end else begin
            een  = ~(4'b0001 << s);
            eseg = disp[s*4 +: 4];
        end
        cmp("digit_en", digit_en, een);
        cmp("seg_num", seg_num, eseg);
        cmp("frame_done", {3'b000, frame_done}, {3'b000, efd});
        cmp("load_ack", {3'b000, load_ack}, {3'b000, eack});
    endtask

    task automatic next_cyc();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    // One full frame from offset 0; up to two loads at given offsets (-1: none).
    task automatic run_frame(input logic [15:0] disp, input logic efd0, input logic eack0,
                             input int off_a, input logic [15:0] val_a, input logic lz_a,
                             input int off_b, input logic [15:0] val_b, input logic lz_b);
        for (int off = 0; off < 4 * SD; off++) begin
            if (off == off_a) begin
                load = 1'b1; value_in = val_a; lz_en_in = lz_a;
            end else if (off == off_b) begin
                load = 1'b1; value_in = val_b; lz_en_in = lz_b;
            end else begin
                load = 1'b0;
            end
            check(disp, (off == 0) ? efd0 : 1'b0, (off == 0) ? eack0 : 1'b0);
            next_cyc();
        end
        load = 1'b0;
    endtask

    initial begin
        logic [15:0] disp;
        logic        ack;

        vecs[0] = '{val: 16'h1234, lz: 1'b0, disp: 16'h1234};
        vecs[1] = '{val: 16'h0070, lz: 1'b1, disp: 16'hFF70};
        vecs[2] = '{val: 16'h0000, lz: 1'b1, disp: 16'hFFF0};
        vecs[3] = '{val: 16'h0070, lz: 1'b0, disp: 16'h0070};
        vecs[4] = '{val: 16'h0E05, lz: 1'b1, disp: 16'hFE05};
        vecs[5] = '{val: 16'h1000, lz: 1'b1, disp: 16'h1000};
        vecs[6] = '{val: 16'h0009, lz: 1'b1, disp: 16'hFFF9};
        vecs[7] = '{val: 16'hFE21, lz: 1'b0, disp: 16'hFE21};

        do_reset();

        // Idle after reset: blank display, frame_done at 32 and 64, no ack.
        run_frame(16'hFFFF, 1'b0, 1'b0, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);
        run_frame(16'hFFFF, 1'b1, 1'b0, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);

        // Table: load mid-frame, expect it shown (and acked) from next frame.
        disp = 16'hFFFF;
        ack  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_frame(disp, 1'b1, ack, 5, vecs[i].val, vecs[i].lz, -1, 16'h0, 1'b0);
            disp = vecs[i].disp;
            ack  = 1'b1;
        end

        // Two loads in one frame: last wins, single ack.
        run_frame(disp, 1'b1, 1'b1, 10, 16'h5555, 1'b0, 20, 16'h0802, 1'b1);
        // Load in the boundary cycle goes straight to the next frame.
        run_frame(16'hF802, 1'b1, 1'b1, 4 * SD - 1, 16'h4321, 1'b0, -1, 16'h0, 1'b0);
        run_frame(16'h4321, 1'b1, 1'b1, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);
        run_frame(16'h4321, 1'b1, 1'b0, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);

        // Reset in slot 2 with a pending load.
        for (int off = 0; off < 18; off++) begin
            load     = (off == 3);
            value_in = 16'h9999;
            lz_en_in = 1'b0;
            check(16'h4321, (off == 0), 1'b0);
            next_cyc();
        end
        load = 1'b0;
        check(16'h4321, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        cmp("rst_seg_num", seg_num, 4'hF);
        cmp("rst_digit_en", digit_en, 4'b1111);
        cmp("rst_load_ack", {3'b000, load_ack}, 4'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        run_frame(16'hFFFF, 1'b0, 1'b0, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);
        run_frame(16'hFFFF, 1'b1, 1'b0, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
